// File: rtl/debounce_timer_scheduler.sv
// N-channel debouncer sharing one delay counter; a round-robin arbiter hands the
// timer to one waiting channel at a time and each channel runs a 4-state FSM.
module debounce_timer_scheduler #(
    parameter int N            = 4,
    parameter int DELAY_CYCLES = 1000000,
    parameter int TW           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         noisy,
    output logic [N-1:0]         debounced,
    output logic [N-1:0]         rise,
    output logic [N-1:0]         fall,
    output logic                 timer_busy,
    output logic [$clog2(N)-1:0] owner_id
);

    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t         r_state [N];
    state_t         w_state_nxt [N];
    logic [N-1:0]   w_req;
    logic [N-1:0]   w_is_owner;
    logic [N-1:0]   w_rise_nxt;
    logic [N-1:0]   w_fall_nxt;
    logic [N-1:0]   w_deb_nxt;
    logic           w_release;
    logic           w_done;
    logic           w_grant;
    logic           w_found;
    int             w_idx;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_ptr_nxt;

    logic [TW-1:0]  r_count;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_ptr;
    logic           r_busy;
    logic [N-1:0]   r_deb;
    logic [N-1:0]   r_rise;
    logic [N-1:0]   r_fall;

    assign w_done = (r_count == TW'(DELAY_CYCLES - 1));

    // Per-channel next state; only the timer owner can complete or free the timer.
    always_comb begin
        w_release  = 1'b0;
        w_req      = '0;
        w_is_owner = '0;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        w_deb_nxt  = '0;
        for (int i = 0; i < N; i++) begin
            w_is_owner[i]  = r_busy && (r_owner == IDW'(i));
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                LO: begin
                    if (noisy[i]) w_state_nxt[i] = WAIT_HI;
                end
                WAIT_HI: begin
                    if (!noisy[i]) begin
                        w_state_nxt[i] = LO;
                        if (w_is_owner[i]) w_release = 1'b1;
                    end else if (w_is_owner[i] && w_done) begin
                        w_state_nxt[i] = HI;
                        w_rise_nxt[i]  = 1'b1;
                        w_release      = 1'b1;
                    end
                end
                HI: begin
                    if (!noisy[i]) w_state_nxt[i] = WAIT_LO;
                end
                WAIT_LO: begin
                    if (noisy[i]) begin
                        w_state_nxt[i] = HI;
                        if (w_is_owner[i]) w_release = 1'b1;
                    end else if (w_is_owner[i] && w_done) begin
                        w_state_nxt[i] = LO;
                        w_fall_nxt[i]  = 1'b1;
                        w_release      = 1'b1;
                    end
                end
                default: w_state_nxt[i] = LO;
            endcase
            w_req[i]     = ((r_state[i] == WAIT_HI) || (r_state[i] == WAIT_LO)) && !w_is_owner[i];
            w_deb_nxt[i] = (w_state_nxt[i] == HI) || (w_state_nxt[i] == WAIT_LO);
        end
    end

    // Cyclic search for the first requester at or after the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && w_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    assign w_grant   = !r_busy && w_found;
    assign w_ptr_nxt = (w_winner == IDW'(N - 1)) ? '0 : w_winner + IDW'(1);

    // A releasing edge never grants, leaving one idle cycle between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_count <= '0;
            r_ptr   <= '0;
        end else if (r_busy) begin
            if (w_release) r_busy <= 1'b0;
            else           r_count <= r_count + TW'(1);
        end else if (w_grant) begin
            r_busy  <= 1'b1;
            r_owner <= w_winner;
            r_count <= '0;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_state[i] <= LO;
            r_deb  <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int i = 0; i < N; i++) r_state[i] <= w_state_nxt[i];
            r_deb  <= w_deb_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign debounced  = r_deb;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign timer_busy = r_busy;
    assign owner_id   = r_owner;

endmodule
